// File: rtl/tt_um_pipelined_riscv_cpu.sv
// Tiny Tapeout wrapper around a 4-stage (IF/ID/EX/WB) RV32I-subset CPU with an
// 8-bit datapath, running a fixed program from a 16-word internal ROM.
module tt_um_pipelined_riscv_cpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR, ALU_OR, ALU_AND} aluOp_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] romWord(input logic [3:0] addr);
    case (addr)
      4'd0:    return 32'h0050_0093;
      4'd1:    return 32'h0030_0113;
      4'd2:    return 32'h0020_81B3;
      4'd3:    return 32'h4020_8233;
      4'd4:    return 32'h0020_F2B3;
      4'd5:    return 32'h0020_E333;
      4'd6:    return 32'h0041_C3B3;
      default: return NOP;
    endcase
  endfunction

  logic [3:0]  pc_q;
  logic [31:0] ifIdInstr_q;
  aluOp_e      idExOp_q;
  logic [7:0]  idExA_q, idExB_q, idExImm_q;
  logic [2:0]  idExRs1_q, idExRs2_q, idExRd_q;
  logic        idExWe_q, idExUseImm_q;
  logic [2:0]  exWbRd_q;
  logic        exWbWe_q;
  logic [7:0]  exWbRes_q;
  logic [7:0]  rf_q [8];
  logic [7:0]  uo_q;
  logic [3:0]  dbgWb_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3, rs1, rs2, rd;
  aluOp_e      decOp_d;
  logic        decValid_d, decUseImm_d, decWe_d;
  logic [7:0]  rdA_d, rdB_d;
  logic [7:0]  opA_d, opB2_d, opB_d, aluRes_d;

  assign opcode = ifIdInstr_q[6:0];
  assign funct3 = ifIdInstr_q[14:12];
  assign rd     = ifIdInstr_q[9:7];
  assign rs1    = ifIdInstr_q[17:15];
  assign rs2    = ifIdInstr_q[22:20];

  always_comb begin
    decOp_d     = ALU_ADD;
    decValid_d  = 1'b0;
    decUseImm_d = 1'b0;
    case (opcode)
      7'b0010011: begin
        decUseImm_d = 1'b1;
        decValid_d  = 1'b1;
        case (funct3)
          3'b000:  decOp_d = ALU_ADD;
          3'b100:  decOp_d = ALU_XOR;
          3'b110:  decOp_d = ALU_OR;
          3'b111:  decOp_d = ALU_AND;
          default: decValid_d = 1'b0;
        endcase
      end
      7'b0110011: begin
        decValid_d = 1'b1;
        case (funct3)
          3'b000:  decOp_d = ifIdInstr_q[30] ? ALU_SUB : ALU_ADD;
          3'b010:  decOp_d = ALU_SLT;
          3'b100:  decOp_d = ALU_XOR;
          3'b110:  decOp_d = ALU_OR;
          3'b111:  decOp_d = ALU_AND;
          default: decValid_d = 1'b0;
        endcase
      end
      default: decValid_d = 1'b0;
    endcase
    // x0 destinations are dropped here so WB never reports a discarded write
    decWe_d = decValid_d && (rd != 3'd0);
  end

  // ID register read with write-through from the instruction retiring this cycle
  always_comb begin
    rdA_d = rf_q[rs1];
    rdB_d = rf_q[rs2];
    if (exWbWe_q && exWbRd_q == rs1) rdA_d = exWbRes_q;
    if (exWbWe_q && exWbRd_q == rs2) rdB_d = exWbRes_q;
  end

  always_comb begin
    opA_d  = (exWbWe_q && exWbRd_q == idExRs1_q) ? exWbRes_q : idExA_q;
    opB2_d = (exWbWe_q && exWbRd_q == idExRs2_q) ? exWbRes_q : idExB_q;
    opB_d  = idExUseImm_q ? idExImm_q : opB2_d;
    case (idExOp_q)
      ALU_SUB: aluRes_d = opA_d - opB_d;
      ALU_SLT: aluRes_d = {7'd0, $signed(opA_d) < $signed(opB_d)};
      ALU_XOR: aluRes_d = opA_d ^ opB_d;
      ALU_OR:  aluRes_d = opA_d | opB_d;
      ALU_AND: aluRes_d = opA_d & opB_d;
      default: aluRes_d = opA_d + opB_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= '0;
      ifIdInstr_q  <= NOP;
      idExOp_q     <= ALU_ADD;
      idExA_q      <= '0;
      idExB_q      <= '0;
      idExImm_q    <= '0;
      idExRs1_q    <= '0;
      idExRs2_q    <= '0;
      idExRd_q     <= '0;
      idExWe_q     <= 1'b0;
      idExUseImm_q <= 1'b0;
      exWbRd_q     <= '0;
      exWbWe_q     <= 1'b0;
      exWbRes_q    <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      uo_q         <= '0;
      dbgWb_q      <= '0;
    end else begin
      pc_q         <= pc_q + 4'd1;
      ifIdInstr_q  <= romWord(pc_q);
      idExOp_q     <= decOp_d;
      idExA_q      <= rdA_d;
      idExB_q      <= rdB_d;
      idExImm_q    <= ifIdInstr_q[27:20];
      idExRs1_q    <= rs1;
      idExRs2_q    <= rs2;
      idExRd_q     <= rd;
      idExWe_q     <= decWe_d;
      idExUseImm_q <= decUseImm_d;
      exWbRd_q     <= idExRd_q;
      exWbWe_q     <= idExWe_q;
      exWbRes_q    <= aluRes_d;
      if (exWbWe_q) rf_q[exWbRd_q] <= exWbRes_q;
      // Observes the register file as it stood before this edge's write
      uo_q         <= rf_q[ui_in[2:0]];
      dbgWb_q      <= {exWbWe_q, exWbRd_q};
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {dbgWb_q, pc_q};
  assign uio_oe  = 8'hFF;

  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in, ui_in[7:3], ifIdInstr_q[31], ifIdInstr_q[29:28],
                           ifIdInstr_q[19:18], ifIdInstr_q[11:10]};

endmodule

// File: tb/tb_tt_um_pipelined_riscv_cpu.sv
// Scoreboard bench: an architectural model of the fixed program predicts uo_out
// and uio_out after every edge; a monitor compares what the CPU presents.
module tb_tt_um_pipelined_riscv_cpu;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'd0;
   logic [7:0] uio_in = 8'd0;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   tt_um_pipelined_riscv_cpu dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .ui_in(ui_in),
      .uio_in(uio_in),
      .uo_out(uo_out),
      .uio_out(uio_out),
      .uio_oe(uio_oe)
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;

   // The program in assembly form: op 0=addi 1=add 2=sub 3=and 4=or 5=xor
   int pOp[7]  = '{0, 0, 1, 2, 3, 4, 5};
   int pRd[7]  = '{1, 2, 3, 4, 5, 6, 7};
   int pRs1[7] = '{0, 0, 1, 1, 1, 1, 3};
   int pRs2[7] = '{0, 0, 2, 2, 2, 2, 4};
   int pImm[7] = '{5, 3, 0, 0, 0, 0, 0};

   logic [7:0] mRf[8];
   int         mEdge = 0;

   // Drives one edge's inputs and pushes the architecturally expected view after that edge
   task automatic applyStimulus(input logic rstVal, input logic [2:0] sel);
      exp_t       e;
      logic       wbWe;
      logic [2:0] wbRd;
      logic [7:0] a, b, res;
      int         k;
      rst_n = rstVal;
      ui_in = {5'($urandom), sel};
      uio_in = 8'($urandom);
      cycle++;
      e.cyc = cycle;
      if (!rstVal) begin
         mEdge = 0;
         for (int i = 0; i < 8; i++) mRf[i] = 8'd0;
         e.uo = 8'd0;
         e.uio = 8'd0;
      end else begin
         mEdge++;
         e.uo = mRf[sel];
         wbWe = 1'b0;
         wbRd = 3'd0;
         if (mEdge >= 4) begin
            k = (mEdge - 4) % 16;
            if (k < 7) begin
               a = mRf[pRs1[k]];
               b = (pOp[k] == 0) ? 8'(pImm[k]) : mRf[pRs2[k]];
               case (pOp[k])
                  0, 1:    res = a + b;
                  2:       res = a - b;
                  3:       res = a & b;
                  4:       res = a | b;
                  default: res = a ^ b;
               endcase
               wbWe = 1'b1;
               wbRd = 3'(pRd[k]);
               mRf[pRd[k]] = res;
            end
         end
         e.uio = {wbWe, wbRd, 4'(mEdge % 16)};
      end
      sbQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compares one scoreboard entry against the outputs presented after its edge
   task automatic checkOutput(input exp_t e);
      checks++;
      if (uo_out !== e.uo) begin
         errors++;
         $display("[TB] FAIL uo_out cycle %0d: got %h expected %h", e.cyc, uo_out, e.uo);
      end
      checks++;
      if (uio_out !== e.uio) begin
         errors++;
         $display("[TB] FAIL uio_out cycle %0d: got %h expected %h", e.cyc, uio_out, e.uio);
      end
      checks++;
      if (uio_oe !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL uio_oe cycle %0d: got %h expected ff", e.cyc, uio_oe);
      end
   endtask

   // Monitor: one output sample per edge, taken just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      $display("[TB] starting");
      applyStimulus(1'b0, 3'd0);
      applyStimulus(1'b0, 3'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'($urandom));
      applyStimulus(1'b0, 3'($urandom));
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'd1);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 3'($urandom));
      for (int s = 0; s < 8; s++) applyStimulus(1'b1, 3'(s));
      applyStimulus(1'b0, 3'd3);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 3'd3);
      for (int i = 0; i < 160; i++)
         applyStimulus(($urandom_range(0, 39) != 0), 3'($urandom));
      for (int s = 0; s < 8; s++) applyStimulus(1'b1, 3'(s));
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_um_pipelined_riscv_cpu.md
# tt_um_pipelined_riscv_cpu

Tiny Tapeout top-level wrapper around a 4-stage pipelined RV32I-subset CPU with 8-bit datapath. The CPU executes a fixed program from an internal 16-word ROM, with operand forwarding between stages. Any register can be read on `uo_out`, and pipeline debug state is driven on `uio_out`.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `ena`  in  1  design-select; ignored.
- `ui_in`  in  8  `[2:0]` selects the register shown on `uo_out`; `[7:3]` unused.
- `uio_in`  in  8  unused.
- `uo_out`  out  8  registered value of register `x[ui_in[2:0]]`.
- `uio_out`  out  8  `[3:0]` fetch PC (word index); `[6:4]` WB-stage rd; `[7]` WB write-enable.
- `uio_oe`  out  8  constant `8'hFF`.

## Operation
- Register file: 8 registers x0–x7, each 8 bits.
  - x0 always reads 0; writes to x0 are discarded.
  - rs1, rs2 and rd use only the low 3 bits of their instruction fields.
- Stages:
  - IF: PC register, ROM read, IF/ID register. PC increments by 1 per cycle, mod 16 (15 wraps to 0).
  - ID: decode, register read, immediate extract, ID/EX register.
  - EX: ALU, EX/WB register.
  - WB: register-file write.
- Supported encodings; anything else decodes as a NOP (no write):
  - OP-IMM (opcode `0010011`): ADDI (f3 `000`), XORI (`100`), ORI (`110`), ANDI (`111`).
  - OP (opcode `0110011`): ADD or SUB (f3 `000`, selected by funct7[5]), SLT (`010`, signed 8-bit compare, result 1 or 0), XOR (`100`), OR (`110`), AND (`111`).
- Immediate is `instr[27:20]` (low 8 bits of the I-immediate).
- All arithmetic is 8-bit with wrap-around; no traps and no flags.
- Hazards; no stalls and no flushes, since there are no branches:
  - EX operand forwarding: if the EX/WB entry writes a nonzero rd equal to the EX instruction's rs, use the EX/WB result.
  - Register-file write-through: an ID read of the register being written in WB that cycle returns the new value.
- ROM contents; word 7 onward is NOP (`addi x0,x0,0`):
  - 0: `addi x1,x0,5`
  - 1: `addi x2,x0,3`
  - 2: `add x3,x1,x2`
  - 3: `sub x4,x1,x2`
  - 4: `and x5,x1,x2`
  - 5: `or x6,x1,x2`
  - 6: `xor x7,x3,x4`
- Final register values: x1=5, x2=3, x3=8, x4=2, x5=1, x6=7, x7=10.
  - The program re-executes after the PC wraps. It is idempotent, so these values stay stable.

## Timing
- Reset (`rst_n`=0 at a rising edge) clears:
  - PC to 0;
  - all pipeline registers to NOP with write-enable 0;
  - all registers to 0;
  - `uo_out` and `uio_out` to 0.
- Reset asserted mid-run takes effect at the next rising edge and discards all in-flight instructions.
- Count edges from the first rising edge with `rst_n`=1 (edge 1). The instruction at ROM word k:
  - is latched into IF/ID at edge k+1;
  - is latched into ID/EX at edge k+2;
  - is latched into EX/WB at edge k+3;
  - writes the register file at edge k+4.
- `uo_out` samples the register file (after the write) and so lags the write by one edge. x1 first reads 5 after edge 5; x7 first reads 10 after edge 11.
- The `ui_in[2:0]` selection is sampled each edge. A change in selection appears on `uo_out` after the next edge.
- `uio_out[3:0]` shows the PC of the instruction currently in IF, updated every edge.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges -> `uo_out`=0, `uio_out`=0, `uio_oe`=`0xFF`.
- Program results: release reset, run 20 edges, sweep `ui_in`=0..7 waiting 1 edge each -> `uo_out` = 0, 5, 3, 8, 2, 1, 7, 10.
- Latency: `ui_in`=1, release reset -> `uo_out`=0 after edges 1–4 and 5 after edge 5. `ui_in`=3 -> `uo_out`=8 first after edge 7 (requires forwarding).
- PC wrap: observe `uio_out[3:0]` over 20 edges -> 1, 2, …, 15, 0, 1, …; register values unchanged after the wrap.
- Mid-run reset: assert `rst_n`=0 at edge 6 for 1 edge -> all registers read 0, then results reappear with the same latency as after the initial reset.
- WB debug: after edge 4 -> `uio_out[7]`=1 and `uio_out[6:4]`=1. After edge 11 (a NOP in WB) -> `uio_out[7]`=0.
